// File: rtl/riscv_legacy_core.sv
`default_nettype none
// ============================================================================
// Module   : riscv_legacy_core
// Brief    : Single-cycle RV32I core with 64-word instruction/data memories.
// Revision : 1.0 - initial release
// ============================================================================

package riscv_legacy_pkg;
    typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4} imm_src_e;
    typedef enum logic [3:0] {ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4,
                              ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9} alu_op_e;
    typedef enum logic {ALU_SRC_RS2 = 1'b0, ALU_SRC_IMM = 1'b1} alu_src_e;
    typedef enum logic [1:0] {RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2, RES_IMM = 2'd3} res_src_e;
    typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_TARGET = 2'd1, PC_JALR = 2'd2} pc_src_e;

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD = 7'b0000011;
    localparam logic [6:0] c_OP_STORE= 7'b0100011;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;
    localparam logic [6:0] c_OP_LUI  = 7'b0110111;
endpackage

// Instruction decoder; branch outcome folds the ALU flags into pc_src.
module riscv_legacy_ctrl
    import riscv_legacy_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       reg_we,
    output logic       mem_we,
    output logic [2:0] imm_src,
    output logic [3:0] alu_ctrl,
    output logic       alu_src,
    output logic [1:0] res_src,
    output logic [1:0] pc_src
);
    logic [3:0] w_alu_fn;
    logic       w_take;

    // SUB only exists in R-type; for I-type funct7 bit 5 selects SRAI alone.
    always_comb begin
        w_alu_fn = ALU_ADD;
        case (funct3)
            3'b000:  w_alu_fn = (opcode == c_OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_fn = ALU_SLL;
            3'b010:  w_alu_fn = ALU_SLT;
            3'b011:  w_alu_fn = ALU_SLTU;
            3'b100:  w_alu_fn = ALU_XOR;
            3'b101:  w_alu_fn = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_fn = ALU_OR;
            default: w_alu_fn = ALU_AND;
        endcase
    end

    always_comb begin
        w_take = 1'b0;
        case (funct3)
            3'b000:  w_take = zero;
            3'b001:  w_take = ~zero;
            3'b100:  w_take = lt;
            3'b101:  w_take = ~lt;
            3'b110:  w_take = ltu;
            3'b111:  w_take = ~ltu;
            default: w_take = 1'b0;
        endcase
    end

    always_comb begin
        reg_we   = 1'b0;
        mem_we   = 1'b0;
        imm_src  = IMM_I;
        alu_ctrl = ALU_ADD;
        alu_src  = ALU_SRC_RS2;
        res_src  = RES_ALU;
        pc_src   = PC_PLUS4;
        case (opcode)
            c_OP_R: begin
                reg_we   = 1'b1;
                alu_ctrl = w_alu_fn;
            end
            c_OP_IMM: begin
                reg_we   = 1'b1;
                alu_ctrl = w_alu_fn;
                alu_src  = ALU_SRC_IMM;
            end
            c_OP_LOAD: begin
                reg_we   = 1'b1;
                alu_src  = ALU_SRC_IMM;
                res_src  = RES_MEM;
            end
            c_OP_STORE: begin
                mem_we   = 1'b1;
                imm_src  = IMM_S;
                alu_src  = ALU_SRC_IMM;
            end
            c_OP_BR: begin
                imm_src  = IMM_B;
                alu_ctrl = ALU_SUB;
                pc_src   = w_take ? PC_TARGET : PC_PLUS4;
            end
            c_OP_JAL: begin
                reg_we   = 1'b1;
                imm_src  = IMM_J;
                res_src  = RES_PC4;
                pc_src   = PC_TARGET;
            end
            c_OP_JALR: begin
                reg_we   = 1'b1;
                alu_src  = ALU_SRC_IMM;
                res_src  = RES_PC4;
                pc_src   = PC_JALR;
            end
            c_OP_LUI: begin
                reg_we   = 1'b1;
                imm_src  = IMM_U;
                res_src  = RES_IMM;
            end
            default: ;
        endcase
    end
endmodule

// ALU with subtract-derived flags used for SLT/SLTU and branch resolution.
module riscv_legacy_alu
    import riscv_legacy_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] y,
    output logic        zero,
    output logic        lt,
    output logic        ltu
);
    logic [32:0] w_diff;

    assign w_diff = {1'b0, a} - {1'b0, b};
    assign ltu    = w_diff[32];
    // Differing signs decide directly; otherwise the difference cannot overflow.
    assign lt     = (a[31] ^ b[31]) ? a[31] : w_diff[31];
    assign zero   = (y == 32'd0);

    always_comb begin
        y = a + b;
        case (op)
            ALU_SUB:  y = w_diff[31:0];
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            ALU_SLT:  y = {31'd0, lt};
            ALU_SLTU: y = {31'd0, ltu};
            default:  y = a + b;
        endcase
    end
endmodule

// 32x32 register file: two async read ports, x0 hardwired to zero.
module riscv_legacy_rf (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] _reg [32];

    // Contents are deliberately not cleared by reset; it only blocks writes.
    always_ff @(posedge clk or negedge rst) begin
        if (rst && we && (wa != 5'd0)) begin
            _reg[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : _reg[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : _reg[ra2];
endmodule

module riscv_legacy_dp
    import riscv_legacy_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:7] instr,
    input  logic [31:0] mem_rd_data,
    input  logic        reg_we,
    input  logic [2:0]  imm_src,
    input  logic [3:0]  alu_ctrl,
    input  logic        alu_src,
    input  logic [1:0]  res_src,
    input  logic [1:0]  pc_src,
    output logic [31:0] pc,
    output logic [31:0] alu_out,
    output logic [31:0] mem_wd_data,
    output logic        zero,
    output logic        lt,
    output logic        ltu
);
    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4, w_pc_target, w_pc_next;
    logic [31:0] w_imm, w_rs1, w_rs2, w_src_b, w_result;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_pc_target = r_pc + w_imm;

    always_comb begin
        w_pc_next = w_pc_plus4;
        case (pc_src)
            PC_TARGET: w_pc_next = w_pc_target;
            PC_JALR:   w_pc_next = {alu_out[31:1], 1'b0};
            default:   w_pc_next = w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= 32'd0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_comb begin
        w_imm = {{20{instr[31]}}, instr[31:20]};
        case (imm_src)
            IMM_S:   w_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   w_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   w_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   w_imm = {instr[31:12], 12'd0};
            default: w_imm = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

    riscv_legacy_rf rf (
        .clk (clk),
        .rst (rst),
        .we  (reg_we),
        .ra1 (instr[19:15]),
        .ra2 (instr[24:20]),
        .wa  (instr[11:7]),
        .wd  (w_result),
        .rd1 (w_rs1),
        .rd2 (w_rs2)
    );

    assign w_src_b = alu_src ? w_imm : w_rs2;

    riscv_legacy_alu u_alu (
        .a    (w_rs1),
        .b    (w_src_b),
        .op   (alu_ctrl),
        .y    (alu_out),
        .zero (zero),
        .lt   (lt),
        .ltu  (ltu)
    );

    always_comb begin
        w_result = alu_out;
        case (res_src)
            RES_MEM: w_result = mem_rd_data;
            RES_PC4: w_result = w_pc_plus4;
            RES_IMM: w_result = w_imm;
            default: w_result = alu_out;
        endcase
    end

    assign pc          = r_pc;
    assign mem_wd_data = w_rs2;
endmodule

module riscv_legacy_cpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] mem_rd_data,
    output logic        reg_we,
    output logic        mem_we,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src,
    output logic [1:0]  res_src,
    output logic [1:0]  pc_src,
    output logic [31:0] alu_out,
    output logic [31:0] mem_wd_data,
    output logic [31:0] pc
);
    logic w_zero, w_lt, w_ltu;

    riscv_legacy_ctrl u_ctrl (
        .opcode    (instr[6:0]),
        .funct3    (instr[14:12]),
        .funct7_b5 (instr[30]),
        .zero      (w_zero),
        .lt        (w_lt),
        .ltu       (w_ltu),
        .reg_we    (reg_we),
        .mem_we    (mem_we),
        .imm_src   (imm_src),
        .alu_ctrl  (alu_ctrl),
        .alu_src   (alu_src),
        .res_src   (res_src),
        .pc_src    (pc_src)
    );

    riscv_legacy_dp dp (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr[31:7]),
        .mem_rd_data (mem_rd_data),
        .reg_we      (reg_we),
        .imm_src     (imm_src),
        .alu_ctrl    (alu_ctrl),
        .alu_src     (alu_src),
        .res_src     (res_src),
        .pc_src      (pc_src),
        .pc          (pc),
        .alu_out     (alu_out),
        .mem_wd_data (mem_wd_data),
        .zero        (w_zero),
        .lt          (w_lt),
        .ltu         (w_ltu)
    );
endmodule

module riscv_legacy_core (
    input  logic        clk,
    input  logic        rst,
    output logic        reg_we,
    output logic        mem_we,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src,
    output logic [1:0]  res_src,
    output logic [1:0]  pc_src,
    output logic [31:0] instr,
    output logic [31:0] alu_out,
    output logic [31:0] mem_rd_data,
    output logic [31:0] mem_wd_data,
    output logic [31:0] pc
);
    // Both memories are loaded hierarchically; address bits above [7:2] alias.
    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    assign instr       = imem[pc[7:2]];
    assign mem_rd_data = dmem[alu_out[7:2]];

    always_ff @(posedge clk or negedge rst) begin
        if (rst && mem_we) begin
            dmem[alu_out[7:2]] <= mem_wd_data;
        end
    end

    riscv_legacy_cpu rv (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .mem_rd_data (mem_rd_data),
        .reg_we      (reg_we),
        .mem_we      (mem_we),
        .imm_src     (imm_src),
        .alu_ctrl    (alu_ctrl),
        .alu_src     (alu_src),
        .res_src     (res_src),
        .pc_src      (pc_src),
        .alu_out     (alu_out),
        .mem_wd_data (mem_wd_data),
        .pc          (pc)
    );
endmodule

`default_nettype wire

// File: tb/tb_riscv_legacy_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_legacy_core
// Brief    : Vector table, directed sequences and random programs vs an ISS.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_legacy_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_we, mem_we, alu_src;
    logic [2:0]  imm_src;
    logic [3:0]  alu_ctrl;
    logic [1:0]  res_src, pc_src;
    logic [31:0] instr, alu_out, mem_rd_data, mem_wd_data, pc;

    int n_pass  = 0;
    int n_total = 0;

    riscv_legacy_core dut (
        .clk (clk), .rst (rst), .reg_we (reg_we), .mem_we (mem_we),
        .imm_src (imm_src), .alu_ctrl (alu_ctrl), .alu_src (alu_src),
        .res_src (res_src), .pc_src (pc_src), .instr (instr), .alu_out (alu_out),
        .mem_rd_data (mem_rd_data), .mem_wd_data (mem_wd_data), .pc (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    // Hold reset, wipe state, let the caller preload, then release.
    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) dut.rv.dp.rf._reg[i] = 32'd0;
        for (int i = 0; i < 64; i++) begin
            dut.imem[i] = 32'd0;
            dut.dmem[i] = 32'd0;
        end
    endtask
    task automatic leave_reset();
        #1 rst = 1'b1;
        #1;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_reg [32];
    logic [31:0] m_dmem [64];
    logic [31:0] m_imem [64];
    logic [31:0] m_pc;

    task automatic m_step();
        logic [31:0] i, a, b, imm_i, imm_s, imm_b, imm_j, nxt, wv, addr;
        logic        wr;
        i     = m_imem[m_pc[7:2]];
        a     = m_reg[i[19:15]];
        b     = m_reg[i[24:20]];
        imm_i = {{20{i[31]}}, i[31:20]};
        imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
        imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        nxt   = m_pc + 32'd4;
        wr    = 1'b0;
        wv    = 32'd0;
        case (i[6:0])
            7'h33, 7'h13: begin
                if (i[6:0] == 7'h13) b = imm_i;
                wr = 1'b1;
                case (i[14:12])
                    3'd0: wv = (i[6:0] == 7'h33 && i[30]) ? a - b : a + b;
                    3'd1: wv = a << b[4:0];
                    3'd2: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: wv = (a < b) ? 32'd1 : 32'd0;
                    3'd4: wv = a ^ b;
                    3'd5: wv = i[30] ? $signed(a) >>> b[4:0] : a >> b[4:0];
                    3'd6: wv = a | b;
                    default: wv = a & b;
                endcase
            end
            7'h03: begin addr = a + imm_i; wv = m_dmem[addr[7:2]]; wr = 1'b1; end
            7'h23: begin addr = a + imm_s; m_dmem[addr[7:2]] = b; end
            7'h63: begin
                case (i[14:12])
                    3'd0: if (a == b) nxt = m_pc + imm_b;
                    3'd1: if (a != b) nxt = m_pc + imm_b;
                    3'd4: if ($signed(a) <  $signed(b)) nxt = m_pc + imm_b;
                    3'd5: if ($signed(a) >= $signed(b)) nxt = m_pc + imm_b;
                    3'd6: if (a <  b) nxt = m_pc + imm_b;
                    3'd7: if (a >= b) nxt = m_pc + imm_b;
                    default: ;
                endcase
            end
            7'h6F: begin wv = m_pc + 32'd4; wr = 1'b1; nxt = m_pc + imm_j; end
            7'h67: begin wv = m_pc + 32'd4; wr = 1'b1; addr = a + imm_i; nxt = {addr[31:1], 1'b0}; end
            7'h37: begin wv = {i[31:12], 12'd0}; wr = 1'b1; end
            default: ;
        endcase
        if (wr && i[11:7] != 5'd0) m_reg[i[11:7]] = wv;
        m_pc = nxt;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [20:0] jimm;
        logic [2:0]  brf [6];
        brf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        f3  = 3'($urandom);
        imm = 12'($urandom);
        case ($urandom_range(0, 12))
            0, 1: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                               rs2, rs1, f3, rd);
            2, 3, 4: begin
                if (f3 == 3'd1) imm[11:5] = 7'h00;
                if (f3 == 3'd5) imm[11:5] = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
                return enc_i(imm, rs1, f3, rd, 7'h13);
            end
            5:    return enc_i(imm, rs1, 3'd2, rd, 7'h03);
            6:    return enc_s(imm, rs2, rs1);
            7, 8: return enc_b({imm, 1'b0}, rs2, rs1, brf[$urandom_range(0, 5)]);
            9: begin
                jimm = 21'($urandom);
                jimm[0] = 1'b0;
                return enc_j(jimm, rd);
            end
            10:   return enc_i(imm, rs1, 3'd0, rd, 7'h67);
            11:   return {20'($urandom), rd, 7'h37};
            default: return {25'($urandom), ($urandom_range(0, 1) == 1) ? 7'h0F : 7'h73};
        endcase
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic        chk_alu;
        logic [3:0]  alu;
        logic [1:0]  res;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{enc_r(7'h00, 2, 1, 3'd0, 3), 32'd5, 32'd7, 1'b1, 4'd0, 2'd0, 32'd12};
        vecs[1]  = '{enc_r(7'h20, 2, 1, 3'd0, 3), 32'd5, 32'd7, 1'b1, 4'd1, 2'd0, 32'hFFFF_FFFE};
        vecs[2]  = '{enc_r(7'h00, 2, 1, 3'd7, 3), 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, 4'd2, 2'd0, 32'h00F0_000F};
        vecs[3]  = '{enc_r(7'h00, 2, 1, 3'd6, 3), 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, 4'd3, 2'd0, 32'hFFF0_0FFF};
        vecs[4]  = '{enc_r(7'h00, 2, 1, 3'd4, 3), 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, 4'd4, 2'd0, 32'hFF00_0FF0};
        vecs[5]  = '{enc_r(7'h00, 2, 1, 3'd1, 3), 32'd1, 32'd33, 1'b1, 4'd5, 2'd0, 32'd2};
        vecs[6]  = '{enc_r(7'h00, 2, 1, 3'd5, 3), 32'h8000_0000, 32'd4, 1'b1, 4'd6, 2'd0, 32'h0800_0000};
        vecs[7]  = '{enc_r(7'h20, 2, 1, 3'd5, 3), 32'h8000_0000, 32'd4, 1'b1, 4'd7, 2'd0, 32'hF800_0000};
        vecs[8]  = '{enc_r(7'h00, 2, 1, 3'd3, 3), 32'hFFFF_FFF8, 32'd2, 1'b1, 4'd9, 2'd0, 32'd0};
        vecs[9]  = '{enc_i(12'hFFF, 1, 3'd0, 3, 7'h13), 32'd0, 32'd0, 1'b1, 4'd0, 2'd0, 32'hFFFF_FFFF};
        vecs[10] = '{enc_i(12'h41F, 1, 3'd5, 3, 7'h13), 32'h8000_0000, 32'd0, 1'b1, 4'd7, 2'd0, 32'hFFFF_FFFF};
        vecs[11] = '{{20'hABCDE, 5'd3, 7'h37}, 32'd0, 32'd0, 1'b0, 4'd0, 2'd3, 32'hABCD_E000};
        vecs[12] = '{enc_i(12'hFFF, 1, 3'd3, 3, 7'h13), 32'd5, 32'd0, 1'b1, 4'd9, 2'd0, 32'd1};
        vecs[13] = '{enc_i(12'h0FF, 1, 3'd7, 3, 7'h13), 32'h1234_5678, 32'd0, 1'b1, 4'd2, 2'd0, 32'h0000_0078};

        for (int v = 0; v < 14; v++) begin
            enter_reset();
            dut.rv.dp.rf._reg[1] = vecs[v].a;
            dut.rv.dp.rf._reg[2] = vecs[v].b;
            dut.rv.dp.rf._reg[3] = 32'h5A5A_5A5A;
            dut.imem[0] = vecs[v].instr;
            leave_reset();
            if (vecs[v].chk_alu) check($sformatf("vec%0d alu_ctrl", v), {28'd0, alu_ctrl}, {28'd0, vecs[v].alu});
            check($sformatf("vec%0d res_src", v), {30'd0, res_src}, {30'd0, vecs[v].res});
            check($sformatf("vec%0d reg_we", v), {31'd0, reg_we}, 32'd1);
            step();
            check($sformatf("vec%0d x3", v), dut.rv.dp.rf._reg[3], vecs[v].exp);
            check($sformatf("vec%0d pc", v), pc, 32'd4);
        end

        // Signed SLT program
        enter_reset();
        dut.rv.dp.rf._reg[5] = 32'd8;  dut.rv.dp.rf._reg[6]  = 32'd2;
        dut.rv.dp.rf._reg[7] = 32'hFFFF_FFF8; dut.rv.dp.rf._reg[8] = 32'd2;
        dut.rv.dp.rf._reg[9] = 32'd2;  dut.rv.dp.rf._reg[10] = 32'd4;
        dut.imem[0] = 32'h0062a233; dut.imem[1] = 32'h0083a233; dut.imem[2] = 32'h00a4a233;
        leave_reset();
        check("reset pc", pc, 32'd0);
        check("reset instr", instr, 32'h0062a233);
        step(); check("slt c1 x4", dut.rv.dp.rf._reg[4], 32'd0);
        step(); check("slt c2 x4", dut.rv.dp.rf._reg[4], 32'd1);
        step(); check("slt c3 x4", dut.rv.dp.rf._reg[4], 32'd1);

        // SLTU with negative-looking operand
        enter_reset();
        dut.rv.dp.rf._reg[7] = 32'hFFFF_FFF8; dut.rv.dp.rf._reg[8] = 32'd2;
        dut.rv.dp.rf._reg[4] = 32'h1111_1111;
        dut.imem[0] = enc_r(7'h00, 8, 7, 3'd3, 4);
        leave_reset();
        check("sltu alu_ctrl", {28'd0, alu_ctrl}, 32'd9);
        check("sltu res_src", {30'd0, res_src}, 32'd0);
        step(); check("sltu x4", dut.rv.dp.rf._reg[4], 32'd0);

        // Store then load
        enter_reset();
        dut.rv.dp.rf._reg[1] = 32'h10; dut.rv.dp.rf._reg[2] = 32'hDEAD_BEEF;
        dut.imem[0] = enc_s(12'd4, 2, 1);
        dut.imem[1] = enc_i(12'd4, 1, 3'd2, 3, 7'h03);
        leave_reset();
        check("sw mem_we", {31'd0, mem_we}, 32'd1);
        check("sw alu_out", alu_out, 32'h14);
        check("sw reg_we", {31'd0, reg_we}, 32'd0);
        step(); check("sw dmem[5]", dut.dmem[5], 32'hDEAD_BEEF);
        check("lw mem_rd_data", mem_rd_data, 32'hDEAD_BEEF);
        step(); check("lw x3", dut.rv.dp.rf._reg[3], 32'hDEAD_BEEF);

        // Taken branch then backward jal
        enter_reset();
        dut.imem[0] = enc_b(13'd8, 0, 0, 3'd0);
        dut.imem[2] = enc_j(21'h1FFFF8, 1);
        leave_reset();
        check("beq pc_src", {30'd0, pc_src}, 32'd1);
        step(); check("beq pc", pc, 32'd8);
        check("jal pc_src", {30'd0, pc_src}, 32'd1);
        check("jal res_src", {30'd0, res_src}, 32'd2);
        step(); check("jal pc", pc, 32'd0);
        check("jal x1", dut.rv.dp.rf._reg[1], 32'd12);

        // Not-taken branch
        enter_reset();
        dut.imem[0] = enc_b(13'd8, 0, 0, 3'd1);
        leave_reset();
        check("bne pc_src", {30'd0, pc_src}, 32'd0);
        step(); check("bne pc", pc, 32'd4);

        // x0 immutability and mid-program reset
        enter_reset();
        dut.imem[0] = enc_i(12'd1, 5, 3'd0, 5, 7'h13);
        dut.imem[1] = enc_i(12'd5, 0, 3'd0, 0, 7'h13);
        dut.imem[2] = enc_i(12'd1, 5, 3'd0, 5, 7'h13);
        leave_reset();
        step(); step(); step();
        check("x0 after addi", dut.rv.dp.rf._reg[0], 32'd0);
        check("x0 read via rf", dut.rv.dp.rf.rd1 | 32'd0, dut.rv.dp.rf.ra1 == 5'd0 ? 32'd0 : dut.rv.dp.rf._reg[dut.rv.dp.rf.ra1]);
        check("x5 before reset", dut.rv.dp.rf._reg[5], 32'd2);
        check("pc before reset", pc, 32'd12);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("pc async reset", pc, 32'd0);
        step();
        check("pc held in reset", pc, 32'd0);
        check("x5 held in reset", dut.rv.dp.rf._reg[5], 32'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("restart instr", instr, enc_i(12'd1, 5, 3'd0, 5, 7'h13));
        step();
        check("restart x5", dut.rv.dp.rf._reg[5], 32'd3);
        check("restart pc", pc, 32'd4);

        // Random programs against the ISS
        for (int run = 0; run < 4; run++) begin
            enter_reset();
            for (int i = 1; i < 32; i++) begin
                m_reg[i] = $urandom;
                dut.rv.dp.rf._reg[i] = m_reg[i];
            end
            m_reg[0] = 32'd0;
            for (int i = 0; i < 64; i++) begin
                m_imem[i] = rand_instr();
                m_dmem[i] = $urandom;
                dut.imem[i] = m_imem[i];
                dut.dmem[i] = m_dmem[i];
            end
            m_pc = 32'd0;
            leave_reset();
            for (int c = 0; c < 300; c++) begin
                m_step();
                step();
                check($sformatf("rand%0d cyc%0d pc", run, c), pc, m_pc);
            end
            for (int i = 0; i < 32; i++)
                check($sformatf("rand%0d x%0d", run, i), dut.rv.dp.rf._reg[i], m_reg[i]);
            for (int i = 0; i < 64; i++)
                check($sformatf("rand%0d dmem%0d", run, i), dut.dmem[i], m_dmem[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
